qed_dup_engine: RTL and testbench

- Parametrised instruction-duplication front end for SQED checking of the 5-stage RISC-V core.
- Sits between the external `instruction` input and the IF stage. Emits original instructions and their register-remapped duplicates as `qed_ifu_instruction` / `qed_vld_out`.
- Generalises the single fixed duplicator with configurable register split, a replay FIFO of configurable depth, and a selectable queued or inline duplication mode.
- Also supports pipeline stall back-pressure and forces unsupported instructions to NOP.

---
 rtl/qed_dup_engine.sv | 208 ++++++++++++++++++++
 tb/tb_qed_dup_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_engine.sv
// qed_dup_engine
//   Instruction-duplication front end for SQED checking. Sits between the
//   external instruction source and the IF stage. It issues each legal
//   original instruction and, later (queued mode) or on the very next cycle
//   (inline mode), a duplicate whose register fields are shifted into the
//   upper register bank (index + REG_SPLIT). Illegal instructions are
//   consumed but issued as an invalid NOP.
//
// Ports
//   clk                  clock, all state changes on rising edge
//   reset                synchronous active-high reset
//   instruction          candidate instruction
//   qed_exec_dup         queued mode: replay the FIFO head as a duplicate
//   ifu_stall            freezes all state; no instruction consumed
//   qed_ready            comb: instruction is consumed this cycle
//   qed_ifu_instruction  registered instruction to IF
//   qed_vld_out          registered: output is a real instruction
//   qed_is_dup           registered: output is a duplicate
//   queue_count          replay FIFO occupancy
//   queue_full/empty     occupancy flags
module qed_dup_engine #(
  parameter int XLEN      = 32,
  parameter int REG_SPLIT = 16,
  parameter int DEPTH     = 8,
  parameter int INLINE    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [XLEN-1:0]              instruction,
  input  logic                         qed_exec_dup,
  input  logic                         ifu_stall,
  output logic                         qed_ready,
  output logic [XLEN-1:0]              qed_ifu_instruction,
  output logic                         qed_vld_out,
  output logic                         qed_is_dup,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  output logic                         queue_full,
  output logic                         queue_empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;
  localparam logic [6:0]      OP_R   = 7'b0110011;
  localparam logic [6:0]      OP_I   = 7'b0010011;
  localparam logic [6:0]      OP_LD  = 7'b0000011;
  localparam logic [6:0]      OP_ST  = 7'b0100011;
  localparam logic [6:0]      OP_LUI = 7'b0110111;

  // 6-bit compare value so REG_SPLIT itself never truncates; 5-bit add value
  // is safe because REG_SPLIT <= 16.
  localparam logic [5:0] RS6 = 6'(REG_SPLIT);
  localparam logic [4:0] RS5 = 5'(REG_SPLIT);

  typedef enum logic {ORIG, DUP} state_e;

  // Register fields touched by each format, as {rd, rs1, rs2}.
  // All-zero means the opcode is unsupported.
  function automatic logic [2:0] used_fields(input logic [6:0] opc);
    case (opc)
      OP_R:        return 3'b111;
      OP_I, OP_LD: return 3'b110;
      OP_ST:       return 3'b011;
      OP_LUI:      return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [XLEN-1:0] ins);
    logic [2:0] u;
    u = used_fields(ins[6:0]);
    return (|u) &&
           !(u[2] && ({1'b0, ins[11:7]}  >= RS6)) &&
           !(u[1] && ({1'b0, ins[19:15]} >= RS6)) &&
           !(u[0] && ({1'b0, ins[24:20]} >= RS6));
  endfunction

  // x0 is hard-wired zero in both banks, so it is never remapped.
  function automatic logic [4:0] remap(input logic [4:0] r);
    return (r == 5'd0) ? r : r + RS5;
  endfunction

  function automatic logic [XLEN-1:0] dup_of(input logic [XLEN-1:0] ins);
    logic [XLEN-1:0] d;
    logic [2:0]      u;
    d = ins;
    u = used_fields(ins[6:0]);
    if (u[2]) d[11:7]  = remap(ins[11:7]);
    if (u[1]) d[19:15] = remap(ins[19:15]);
    if (u[0]) d[24:20] = remap(ins[24:20]);
    return d;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  logic [XLEN-1:0] out_q, out_d;
  logic            vld_q, vld_d;
  logic            isdup_q, isdup_d;
  logic [XLEN-1:0] hold_q, hold_d;
  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic            push, pop, legal, full, empty;

  assign legal = is_legal(instruction);
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    qed_ready = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    out_d     = out_q;
    vld_d     = vld_q;
    isdup_d   = isdup_q;
    hold_d    = hold_q;
    state_d   = state_q;
    if (!ifu_stall) begin
      if (INLINE != 0) begin
        case (state_q)
          ORIG: begin
            qed_ready = 1'b1;
            isdup_d   = 1'b0;
            if (legal) begin
              out_d   = instruction;
              vld_d   = 1'b1;
              hold_d  = instruction;
              state_d = DUP;
            end else begin
              out_d = NOP;
              vld_d = 1'b0;
            end
          end
          DUP: begin
            out_d   = dup_of(hold_q);
            vld_d   = 1'b1;
            isdup_d = 1'b1;
            state_d = ORIG;
          end
          default: state_d = ORIG;
        endcase
      end else begin
        isdup_d = 1'b0;
        out_d   = NOP;
        vld_d   = 1'b0;
        if (!qed_exec_dup) begin
          // A full queue refuses the instruction outright, legal or not.
          if (!full) begin
            qed_ready = 1'b1;
            push      = legal;
            if (legal) begin
              out_d = instruction;
              vld_d = 1'b1;
            end
          end
        end else if (!empty) begin
          pop     = 1'b1;
          out_d   = dup_of(mem_q[rd_ptr_q]);
          vld_d   = 1'b1;
          isdup_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= NOP;
      vld_q    <= 1'b0;
      isdup_q  <= 1'b0;
      hold_q   <= NOP;
      state_q  <= ORIG;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (!ifu_stall) begin
      out_q   <= out_d;
      vld_q   <= vld_d;
      isdup_q <= isdup_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        cnt_q    <= cnt_q + 1'b1;
      end else if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        cnt_q    <= cnt_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= instruction;
  end

  assign qed_ifu_instruction = out_q;
  assign qed_vld_out         = vld_q;
  assign qed_is_dup          = isdup_q;
  assign queue_count         = cnt_q;
  assign queue_full          = full;
  assign queue_empty         = empty;

endmodule

// File: tb/tb_qed_dup_engine.sv
// Bench for qed_dup_engine: one queued-mode and one inline-mode instance run
// in lockstep against a behavioural model (queue of originals / pending flag).
module tb_qed_dup_engine;
  localparam int          RS    = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] q_instr = '0, i_instr = '0;
  logic        q_exec = 0, q_stall = 0, i_exec = 0, i_stall = 0;
  logic        q_ready, q_vld, q_dup, q_full, q_empty;
  logic        i_ready, i_vld, i_dup, i_full, i_empty;
  logic [31:0] q_out, i_out;
  logic [3:0]  q_cnt, i_cnt;

  always #5 clk = ~clk;

  qed_dup_engine #(.XLEN(32), .REG_SPLIT(RS), .DEPTH(DEPTH), .INLINE(0)) u_q (
    .clk(clk), .reset(reset), .instruction(q_instr), .qed_exec_dup(q_exec),
    .ifu_stall(q_stall), .qed_ready(q_ready), .qed_ifu_instruction(q_out),
    .qed_vld_out(q_vld), .qed_is_dup(q_dup), .queue_count(q_cnt),
    .queue_full(q_full), .queue_empty(q_empty));

  qed_dup_engine #(.XLEN(32), .REG_SPLIT(RS), .DEPTH(DEPTH), .INLINE(1)) u_i (
    .clk(clk), .reset(reset), .instruction(i_instr), .qed_exec_dup(i_exec),
    .ifu_stall(i_stall), .qed_ready(i_ready), .qed_ifu_instruction(i_out),
    .qed_vld_out(i_vld), .qed_is_dup(i_dup), .queue_count(i_cnt),
    .queue_full(i_full), .queue_empty(i_empty));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // bit0=rd, bit1=rs1, bit2=rs2 ; 0 = unsupported opcode
  function automatic int fmask(input logic [31:0] x);
    case (x[6:0])
      7'h33:        return 7;
      7'h13, 7'h03: return 3;
      7'h23:        return 6;
      7'h37:        return 1;
      default:      return 0;
    endcase
  endfunction

  function automatic int fpos(input int f);
    return (f == 0) ? 7 : ((f == 1) ? 15 : 20);
  endfunction

  function automatic bit m_legal(input logic [31:0] x);
    int m = fmask(x);
    if (m == 0) return 0;
    for (int f = 0; f < 3; f++)
      if (m[f] && (((x >> fpos(f)) & 32'd31) >= 32'(RS))) return 0;
    return 1;
  endfunction

  // Register fields of a legal instruction are < RS, so adding RS in place
  // never carries into a neighbouring field.
  function automatic logic [31:0] m_dup(input logic [31:0] x);
    logic [31:0] y = x;
    int m = fmask(x);
    for (int f = 0; f < 3; f++)
      if (m[f] && (((x >> fpos(f)) & 32'd31) != 0)) y = y + (32'(RS) << fpos(f));
    return y;
  endfunction

  logic [31:0] mq[$];
  logic [31:0] mq_out, mi_out, mi_hold;
  bit mq_vld, mq_dup, mq_rdy, mi_vld, mi_dup, mi_rdy, mi_pend;
  bit last_q_rdy, last_i_rdy;

  task automatic model_reset();
    mq.delete();
    mq_out = NOP; mq_vld = 0; mq_dup = 0;
    mi_out = NOP; mi_vld = 0; mi_dup = 0; mi_pend = 0;
  endtask

  task automatic check_outputs();
    chk("q_out", q_out, mq_out);
    chk("q_vld", 32'(q_vld), 32'(mq_vld));
    chk("q_dup", 32'(q_dup), 32'(mq_dup));
    chk("q_cnt", 32'(q_cnt), 32'(mq.size()));
    chk("q_full", 32'(q_full), 32'(mq.size() == DEPTH));
    chk("q_empty", 32'(q_empty), 32'(mq.size() == 0));
    chk("i_out", i_out, mi_out);
    chk("i_vld", 32'(i_vld), 32'(mi_vld));
    chk("i_dup", 32'(i_dup), 32'(mi_dup));
    chk("i_cnt", 32'(i_cnt), 32'd0);
  endtask

  task automatic step(input logic [31:0] qi, input logic qe, input logic qs,
                      input logic [31:0] ii, input logic ie, input logic is);
    q_instr = qi; q_exec = qe; q_stall = qs;
    i_instr = ii; i_exec = ie; i_stall = is;
    #1;
    // queued-mode expectation
    if (qs) mq_rdy = 0;
    else if (!qe) begin
      if (mq.size() < DEPTH) begin
        mq_rdy = 1; mq_dup = 0;
        if (m_legal(qi)) begin mq.push_back(qi); mq_out = qi; mq_vld = 1; end
        else begin mq_out = NOP; mq_vld = 0; end
      end else begin
        mq_rdy = 0; mq_out = NOP; mq_vld = 0; mq_dup = 0;
      end
    end else begin
      mq_rdy = 0;
      if (mq.size() > 0) begin mq_out = m_dup(mq.pop_front()); mq_vld = 1; mq_dup = 1; end
      else begin mq_out = NOP; mq_vld = 0; mq_dup = 0; end
    end
    // inline-mode expectation
    if (is) mi_rdy = 0;
    else if (mi_pend) begin
      mi_rdy = 0; mi_out = m_dup(mi_hold); mi_vld = 1; mi_dup = 1; mi_pend = 0;
    end else begin
      mi_rdy = 1; mi_dup = 0;
      if (m_legal(ii)) begin mi_out = ii; mi_vld = 1; mi_hold = ii; mi_pend = 1; end
      else begin mi_out = NOP; mi_vld = 0; end
    end
    last_q_rdy = q_ready; last_i_rdy = i_ready;
    chk("q_ready", 32'(q_ready), 32'(mq_rdy));
    chk("i_ready", 32'(i_ready), 32'(mi_rdy));
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1;
    q_instr = $urandom; i_instr = $urandom; q_exec = 1'($urandom); i_exec = 1'($urandom);
    q_stall = 1; i_stall = 1;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    reset = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 6))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h37;
      5: r[6:0] = 7'h63;
      default: ;
    endcase
    r[11:7]  = 5'($urandom_range(0, 18));
    r[19:15] = 5'($urandom_range(0, 18));
    r[24:20] = 5'($urandom_range(0, 18));
    return r;
  endfunction

  function automatic logic [31:0] add_k(input int k);
    return (k << 20) | (k << 15) | (k << 7) | 32'h33;
  endfunction

  typedef struct {
    logic [31:0] ins; logic ex, st, rdy;
    logic [31:0] out; logic vld, dup; int cnt;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{32'h002081B3, 0, 0, 1, 32'h002081B3, 1, 0, 1};
    tbl[1]  = '{32'h00500093, 0, 1, 0, 32'h002081B3, 1, 0, 1};
    tbl[2]  = '{32'h00000000, 1, 0, 0, 32'h012889B3, 1, 1, 0};
    tbl[3]  = '{32'h00500093, 0, 0, 1, 32'h00500093, 1, 0, 1};
    tbl[4]  = '{32'h00000000, 1, 0, 0, 32'h00500893, 1, 1, 0};
    tbl[5]  = '{32'h01400A33, 0, 0, 1, NOP,          0, 0, 0};
    tbl[6]  = '{32'h00208463, 0, 0, 1, NOP,          0, 0, 0};
    tbl[7]  = '{32'h0000A803, 0, 0, 1, NOP,          0, 0, 0};
    tbl[8]  = '{32'h00000000, 1, 0, 0, NOP,          0, 0, 0};
    tbl[9]  = '{32'h0020AA23, 0, 0, 1, 32'h0020AA23, 1, 0, 1};
    tbl[10] = '{32'hFFFFF2B7, 0, 0, 1, 32'hFFFFF2B7, 1, 0, 2};
    tbl[11] = '{32'hFFF78793, 0, 0, 1, 32'hFFF78793, 1, 0, 3};
    tbl[12] = '{32'h00000000, 1, 1, 0, 32'hFFF78793, 1, 0, 3};
    tbl[13] = '{32'h00000000, 1, 0, 0, 32'h0128AA23, 1, 1, 2};
    tbl[14] = '{32'h00000000, 1, 0, 0, 32'hFFFFFAB7, 1, 1, 1};
    tbl[15] = '{32'h00000000, 1, 0, 0, 32'hFFFF8F93, 1, 1, 0};

    // reset with stall held and random inputs
    model_reset();
    do_reset(2);
    chk("rst_out", q_out, NOP);
    chk("rst_empty", 32'(q_empty), 32'd1);

    // directed queued-mode vectors (inline instance kept stalled)
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].ins, tbl[i].ex, tbl[i].st, 32'h0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_rdy", i), 32'(last_q_rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_out", i), q_out, tbl[i].out);
      chk($sformatf("tbl%0d_vld", i), 32'(q_vld), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_dup", i), 32'(q_dup), 32'(tbl[i].dup));
      chk($sformatf("tbl%0d_cnt", i), 32'(q_cnt), 32'(tbl[i].cnt));
    end

    // fill the FIFO, then refuse, then drain in order
    do_reset(1);
    for (int k = 1; k <= DEPTH; k++) step(add_k(k), 0, 0, 32'h0, 0, 1);
    chk("fill_full", 32'(q_full), 32'd1);
    chk("fill_cnt", 32'(q_cnt), 32'd8);
    step(add_k(9), 0, 0, 32'h0, 0, 1);
    chk("full_ready", 32'(last_q_rdy), 32'd0);
    chk("full_vld", 32'(q_vld), 32'd0);
    chk("full_cnt", 32'(q_cnt), 32'd8);
    for (int k = 1; k <= DEPTH; k++) begin
      step(32'h0, 1, 0, 32'h0, 0, 1);
      chk($sformatf("drain%0d", k), q_out, add_k(k + RS));
      chk($sformatf("drain%0d_dup", k), 32'(q_dup), 32'd1);
    end
    chk("drain_empty", 32'(q_empty), 32'd1);

    // mid-operation reset discards the queue
    step(32'h002081B3, 0, 0, 32'h0, 0, 1);
    step(32'h00500093, 0, 0, 32'h0, 0, 1);
    do_reset(1);
    chk("midrst_cnt", 32'(q_cnt), 32'd0);

    // inline mode with a stall while in DUP
    step(32'h0, 0, 1, 32'h002081B3, 0, 0);
    chk("inl_orig", i_out, 32'h002081B3);
    chk("inl_rdy1", 32'(last_i_rdy), 32'd1);
    step(32'h0, 0, 1, 32'h00500093, 1, 1);
    chk("inl_hold1", i_out, 32'h002081B3);
    step(32'h0, 0, 1, 32'h00500093, 0, 1);
    chk("inl_hold2", i_out, 32'h002081B3);
    step(32'h0, 0, 1, 32'h00500093, 0, 0);
    chk("inl_dup", i_out, 32'h012889B3);
    chk("inl_isdup", 32'(i_dup), 32'd1);
    chk("inl_rdy0", 32'(last_i_rdy), 32'd0);
    step(32'h0, 0, 1, 32'h01400A33, 0, 0);
    chk("inl_illegal_vld", 32'(i_vld), 32'd0);
    chk("inl_illegal_rdy", 32'(last_i_rdy), 32'd1);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 63) == 0) do_reset(1);
      else step(rand_instr(), ($urandom_range(0, 9) < 4), ($urandom_range(0, 7) == 0),
                rand_instr(), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
